// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: load/store controller for the 256x16 CPU data RAM.
// A single request is one burst of 1..16 beats: a load stream returning one
// response per word, or a constant-value store fill returning one acknowledge.
// Every output is a register, so there is no input-to-output combinational path.
module cpu_mem_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_store,
    output logic              rsp_last,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_beats;
    logic [DATA_W-1:0] r_wdata;
    logic              r_op;          // 1 = store/fill, 0 = load
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_store;
    logic              r_rsp_last;
    logic              r_rsp_valid;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_ram_re;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;

    logic [ADDR_W-1:0] w_next_addr;

    // Next burst address; wraps modulo the RAM size.
    assign w_next_addr = r_cur_addr + ADDR_W'(1);

    // The RAM pins and handshake outputs are loaded one cycle ahead of the
    // state they belong to, so each is valid for exactly the cycle the FSM
    // spends in that state; ram_addr/ram_din hold when the enables drop.
    // Burst FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_beats     <= '0;
            r_wdata     <= '0;
            r_op        <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_store <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_ram_re    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_we;
                        r_cur_addr  <= req_addr;
                        r_beats     <= req_len;
                        r_wdata     <= req_wdata;
                        r_ram_addr  <= req_addr;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (req_we) begin
                            r_ram_we  <= 1'b1;
                            r_ram_din <= req_wdata;
                        end else begin
                            r_ram_re  <= 1'b1;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_op) begin
                        if (r_beats == '0) begin
                            r_ram_we    <= 1'b0;
                            r_rsp_data  <= '0;
                            r_rsp_store <= 1'b1;
                            r_rsp_last  <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_cur_addr <= w_next_addr;
                            r_beats    <= r_beats - LEN_W'(1);
                            r_ram_addr <= w_next_addr;
                        end
                    end else begin
                        r_ram_re <= 1'b0;
                        r_state  <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    r_rsp_data  <= ram_dout;
                    r_rsp_store <= 1'b0;
                    r_rsp_last  <= (r_beats == '0);
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (!r_op && (r_beats != '0)) begin
                            r_cur_addr <= w_next_addr;
                            r_beats    <= r_beats - LEN_W'(1);
                            r_ram_addr <= w_next_addr;
                            r_ram_re   <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_ram_re    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign busy         = r_busy;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_store    = r_rsp_store;
    assign rsp_last     = r_rsp_last;
    assign ram_read_en  = r_ram_re;
    assign ram_write_en = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_din      = r_ram_din;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: directed and randomized checks of cpu_mem_ctrl against a
// behavioural RAM and a word-array reference model of burst semantics.
module tb_cpu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_store;
    logic        rsp_last;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        busy;

    logic [15:0] ram     [256];
    logic [15:0] ref_mem [256];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic        nx_we;
    logic [7:0]  nx_addr;
    logic [15:0] nx_wdata;
    logic [3:0]  nx_len;

    cpu_mem_ctrl #(
        .ADDR_W(8),
        .DATA_W(16),
        .LEN_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_len     (req_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_store   (rsp_store),
        .rsp_last    (rsp_last),
        .ram_read_en (ram_read_en),
        .ram_write_en(ram_write_en),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; never reset.
    always @(posedge clk) begin
        if (ram_write_en) ram[ram_addr] <= ram_din;
        if (ram_read_en)  ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one request and follow it to its final response, checking RAM
    // traffic, response contents, latency and handshake behaviour.
    task automatic run_req(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                           input logic [3:0] len, input int unsigned stall0,
                           input int unsigned rdy_pct, input bit hold_busy);
        logic [15:0] exp_q[$];
        int unsigned total, nrsp, nwr, nrd, cyc, first_rsp, wait_cyc, stalled;
        bit          done, exp_re, prev_hold;
        logic [15:0] prev_data, exp_data;
        logic        prev_last;

        total = we ? 1 : 32'(len) + 1;
        for (int i = 0; i <= int'(len); i++) begin
            if (we) ref_mem[8'(addr + 8'(i))] = wd;
            else    exp_q.push_back(ref_mem[8'(addr + 8'(i))]);
        end

        req_we = we; req_addr = addr; req_wdata = wd; req_len = len; req_valid = 1'b1;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 100) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(req_ready), 32'(1));
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (hold_busy) begin
            req_we = nx_we; req_addr = nx_addr; req_wdata = nx_wdata; req_len = nx_len;
        end else begin
            req_valid = 1'b0;
        end

        cyc = 1; done = 0; first_rsp = 0; nrsp = 0; nwr = 0; nrd = 0;
        exp_re = 0; prev_hold = 0; stalled = 0; prev_data = '0; prev_last = 1'b0;
        while (!done && cyc < 400) begin
            chk("excl", 32'(ram_read_en && ram_write_en), 32'(0));
            chk("ready_while_busy", 32'(req_ready), 32'(0));
            chk("busy", 32'(busy), 32'(1));
            if (exp_re) chk("re_after_hs", 32'(ram_read_en), 32'(1));
            exp_re = 0;
            if (prev_hold) begin
                chk("hold_valid", 32'(rsp_valid), 32'(1));
                chk("hold_data", 32'(rsp_data), 32'(prev_data));
                chk("hold_last", 32'(rsp_last), 32'(prev_last));
            end
            if (ram_write_en) begin
                chk("wr_on_load", 32'(we), 32'(1));
                chk("wr_addr", 32'(ram_addr), 32'(8'(addr + 8'(nwr))));
                chk("wr_din", 32'(ram_din), 32'(wd));
                nwr++;
            end
            if (ram_read_en) begin
                chk("rd_addr", 32'(ram_addr), 32'(8'(addr + 8'(nrd))));
                chk("rd_in_resp", 32'(rsp_valid), 32'(0));
                nrd++;
            end
            if (rsp_valid) begin
                if (first_rsp == 0) first_rsp = cyc;
                if (nrsp == 0 && stalled < stall0) begin
                    rsp_ready = 1'b0;
                    stalled++;
                end else begin
                    rsp_ready = ($urandom_range(99) < rdy_pct);
                end
                if (rsp_ready) begin
                    exp_data = (we || nrsp >= exp_q.size()) ? 16'h0000 : exp_q[nrsp];
                    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
                    chk("rsp_store", 32'(rsp_store), 32'(we));
                    chk("rsp_last", 32'(rsp_last), 32'(nrsp == total - 1));
                    nrsp++;
                    if (nrsp == total) done = 1;
                    else if (!we) exp_re = 1;
                end
                prev_hold = !rsp_ready;
                prev_data = rsp_data;
                prev_last = rsp_last;
            end else begin
                rsp_ready = 1'($urandom_range(1));
                prev_hold = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) chk("rsp_timeout", 32'(nrsp), 32'(total));
        chk("n_writes", nwr, we ? 32'(len) + 1 : 0);
        chk("n_reads", nrd, we ? 0 : 32'(len) + 1);
        chk("latency", first_rsp, we ? 32'(len) + 2 : 3);
        chk("idle_after", 32'(busy), 32'(0));
        chk("rsp_valid_after", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'hA500 ^ 16'(i);
            ref_mem[i] = 16'hA500 ^ 16'(i);
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_len = '0; rsp_ready = 1'b0;
        nx_we = 1'b0; nx_addr = '0; nx_wdata = '0; nx_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_re", 32'(ram_read_en), 32'(0));
        chk("rst_we", 32'(ram_write_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_din", 32'(ram_din), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_rsp_store", 32'(rsp_store), 32'(0));
        chk("rst_rsp_last", 32'(rsp_last), 32'(0));

        // Single store then load
        run_req(1'b1, 8'h10, 16'hBEEF, 4'd0, 0, 100, 0);
        run_req(1'b0, 8'h10, 16'h0000, 4'd0, 0, 100, 0);

        // Fill burst across the address wrap, then read it back
        run_req(1'b1, 8'hFE, 16'h1234, 4'd3, 0, 100, 0);
        run_req(1'b0, 8'hFE, 16'h0000, 4'd3, 0, 100, 0);

        // Backpressure on beat 0 of a two-beat load
        run_req(1'b0, 8'hFF, 16'h0000, 4'd1, 5, 100, 0);

        // Second request held valid throughout a load burst
        nx_we = 1'b1; nx_addr = 8'h80; nx_wdata = 16'h7777; nx_len = 4'd0;
        run_req(1'b0, 8'hFE, 16'h0000, 4'd3, 0, 100, 1);
        chk("accept_next_ready", 32'(req_ready), 32'(1));
        run_req(nx_we, nx_addr, nx_wdata, nx_len, 0, 100, 0);
        run_req(1'b0, 8'h80, 16'h0000, 4'd0, 0, 100, 0);

        // Reset during the third beat of an eight-beat fill
        run_req(1'b1, 8'h40, 16'h5A5A, 4'd7, 0, 100, 0);
        req_we = 1'b1; req_addr = 8'h40; req_wdata = 16'hC0DE; req_len = 4'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_we", 32'(ram_write_en), 32'(1));
        chk("mid_addr", 32'(ram_addr), 32'(8'h42));
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_we", 32'(ram_write_en), 32'(0));
        chk("mrst_re", 32'(ram_read_en), 32'(0));
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        chk("mrst_ram_addr", 32'(ram_addr), 32'(0));
        chk("mrst_ram_din", 32'(ram_din), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_req_ready", 32'(req_ready), 32'(1));
        ref_mem[8'h40] = 16'hC0DE;
        ref_mem[8'h41] = 16'hC0DE;
        run_req(1'b0, 8'h40, 16'h0000, 4'd7, 0, 100, 0);

        // Randomized load/store mix with random backpressure
        for (int n = 0; n < 1000; n++) begin
            run_req(1'($urandom_range(1)), 8'($urandom), 16'($urandom), 4'($urandom_range(15)),
                    $urandom_range(3), 70, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
